// File: rtl/friet_state_io_buffer.sv
// Word-serial state buffer between the register front end and the Friet core:
// shifts in 32-bit words, launches the core on a frozen state, rotates the result out.
module friet_state_io_buffer #(
   parameter int STATE_SIZE = 384,
   parameter int WORD_SIZE  = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [WORD_SIZE-1:0]  din_word,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic                  start,
   output logic [WORD_SIZE-1:0]  dout_word,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  core_start,
   output logic [STATE_SIZE-1:0] core_state,
   input  logic [STATE_SIZE-1:0] core_new_state,
   input  logic                  core_done,
   input  logic                  core_fault,
   output logic                  busy,
   output logic                  fault,
   output logic [3:0]            word_count,
   output logic [1:0]            o_dbg_state
);

   localparam int         WORDS     = STATE_SIZE / WORD_SIZE;
   localparam logic [3:0] LAST_WORD = 4'(WORDS - 1);

   // Handshake rule for both ports: a word moves on a rising edge where valid
   // and ready are both high; valid is never withdrawn by this block once raised.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic [STATE_SIZE-1:0] r_buf;
   logic [3:0]            r_word_count;
   logic                  r_core_start;
   logic                  r_fault;
   logic                  w_last_word;

   assign w_last_word = (r_word_count == LAST_WORD);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state      <= ST_IDLE;
         r_buf        <= '0;
         r_word_count <= '0;
         r_core_start <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         r_core_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // New words enter at the top so the first of a full burst lands in word 0.
               if (din_valid) begin
                  r_buf        <= {din_word, r_buf[STATE_SIZE-1:WORD_SIZE]};
                  r_word_count <= w_last_word ? 4'd0 : r_word_count + 4'd1;
               end
               if (start) begin
                  r_core_start <= 1'b1;
                  r_word_count <= '0;
                  r_fault      <= 1'b0;
                  r_state      <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (core_done) begin
                  r_buf   <= core_new_state;
                  r_fault <= core_fault;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Rotate rather than shift so the result is intact after a full read.
               if (dout_ready) begin
                  r_buf <= {r_buf[WORD_SIZE-1:0], r_buf[STATE_SIZE-1:WORD_SIZE]};
                  if (w_last_word) begin
                     r_word_count <= '0;
                     r_state      <= ST_IDLE;
                  end else begin
                     r_word_count <= r_word_count + 4'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign din_ready   = (r_state == ST_IDLE);
   assign dout_valid  = (r_state == ST_DONE);
   assign busy        = (r_state == ST_RUN);
   assign dout_word   = r_buf[WORD_SIZE-1:0];
   assign core_state  = r_buf;
   assign core_start  = r_core_start;
   assign fault       = r_fault;
   assign word_count  = r_word_count;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_friet_state_io_buffer.sv
// Directed bench for friet_state_io_buffer: bench-side buffer model, expected
// result words queued when the core answers and checked as they are unloaded.
module tb_friet_state_io_buffer;

   localparam int SS = 384;
   localparam int WS = 32;
   localparam int NW = 12;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [WS-1:0] din_word;
   logic          din_valid;
   logic          din_ready;
   logic          start;
   logic [WS-1:0] dout_word;
   logic          dout_valid;
   logic          dout_ready;
   logic          core_start;
   logic [SS-1:0] core_state;
   logic [SS-1:0] core_new_state;
   logic          core_done;
   logic          core_fault;
   logic          busy;
   logic          fault;
   logic [3:0]    word_count;
   logic [1:0]    dbg_state;

   logic [WS-1:0] exp_q[$];
   logic [SS-1:0] m_buf;
   int            m_count;
   int            total = 0;
   int            bad = 0;
   int            n_starts = 0;
   int            n0;

   friet_state_io_buffer #(.STATE_SIZE(SS), .WORD_SIZE(WS)) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .din_word       (din_word),
      .din_valid      (din_valid),
      .din_ready      (din_ready),
      .start          (start),
      .dout_word      (dout_word),
      .dout_valid     (dout_valid),
      .dout_ready     (dout_ready),
      .core_start     (core_start),
      .core_state     (core_state),
      .core_new_state (core_new_state),
      .core_done      (core_done),
      .core_fault     (core_fault),
      .busy           (busy),
      .fault          (fault),
      .word_count     (word_count),
      .o_dbg_state    (dbg_state)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) begin
      if (core_start === 1'b1) n_starts++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [SS-1:0] obs, input logic [SS-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_din_ready"}, SS'(din_ready), SS'(1));
      chk({tag, "_dout_valid"}, SS'(dout_valid), '0);
      chk({tag, "_busy"}, SS'(busy), '0);
      chk({tag, "_core_start"}, SS'(core_start), '0);
      chk({tag, "_fault"}, SS'(fault), '0);
      chk({tag, "_word_count"}, SS'(word_count), '0);
      chk({tag, "_core_state"}, core_state, '0);
      chk({tag, "_state"}, SS'(dbg_state), '0);
   endtask

   task automatic load_word(input logic [WS-1:0] w);
      din_valid = 1'b1;
      din_word  = w;
      chk("load_din_ready", SS'(din_ready), SS'(1));
      tick;
      m_buf   = {w, m_buf[SS-1:WS]};
      m_count = (m_count + 1) % NW;
      din_valid = 1'b0;
      chk("load_word_count", SS'(word_count), SS'(m_count));
   endtask

   task automatic do_start;
      start = 1'b1;
      tick;
      start   = 1'b0;
      m_count = 0;
      chk("start_core_start", SS'(core_start), SS'(1));
      chk("start_busy", SS'(busy), SS'(1));
      chk("start_din_ready", SS'(din_ready), '0);
      chk("start_dout_valid", SS'(dout_valid), '0);
      chk("start_word_count", SS'(word_count), '0);
      chk("start_core_state", core_state, m_buf);
   endtask

   // Core model: answers ~core_state after lat cycles; expected words come from m_buf.
   task automatic run_core(input int lat, input logic f);
      for (int i = 1; i < lat; i++) begin
         tick;
         chk("run_busy", SS'(busy), SS'(1));
         chk("run_core_start", SS'(core_start), '0);
      end
      core_done      = 1'b1;
      core_new_state = ~core_state;
      core_fault     = f;
      for (int i = 0; i < NW; i++) exp_q.push_back(~m_buf[i*WS +: WS]);
      m_buf = ~m_buf;
      tick;
      core_done      = 1'b0;
      core_fault     = 1'b0;
      core_new_state = '0;
      chk("done_dout_valid", SS'(dout_valid), SS'(1));
      chk("done_busy", SS'(busy), '0);
      chk("done_fault", SS'(fault), SS'(f));
      chk("done_core_state", core_state, m_buf);
   endtask

   task automatic unload(input int n);
      for (int i = 0; i < n; i++) begin
         int b = 0;
         dout_ready = 1'b1;
         while (dout_valid !== 1'b1 && b < 20) begin
            tick;
            b++;
         end
         chk("unload_dout_valid", SS'(dout_valid), SS'(1));
         chk("unload_word_count", SS'(word_count), SS'(m_count));
         chk("unload_q_nonempty", SS'(exp_q.size() > 0), SS'(1));
         if (exp_q.size() > 0) chk("unload_dout_word", SS'(dout_word), SS'(exp_q.pop_front()));
         tick;
         m_count = (m_count + 1) % NW;
      end
      dout_ready = 1'b0;
   endtask

   initial begin
      aresetn = 1'b0; din_word = '0; din_valid = 1'b0; start = 1'b0; dout_ready = 1'b0;
      core_new_state = '0; core_done = 1'b0; core_fault = 1'b0;
      m_buf = '0; m_count = 0;

      // Reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         din_word       = $urandom;
         din_valid      = 1'($urandom_range(0, 1));
         start          = 1'($urandom_range(0, 1));
         dout_ready     = 1'($urandom_range(0, 1));
         core_done      = 1'($urandom_range(0, 1));
         core_fault     = 1'($urandom_range(0, 1));
         core_new_state = {NW{32'($urandom)}};
         tick;
         chk_reset("rst_hold");
      end
      din_valid = 1'b0; start = 1'b0; dout_ready = 1'b0; core_done = 1'b0;
      core_fault = 1'b0; core_new_state = '0;
      aresetn = 1'b1;
      tick;
      chk_reset("rst_release");

      // Nominal run with backpressure after word 3
      for (int i = 0; i < NW; i++) load_word(32'(i));
      chk("nom_wc_wrap", SS'(word_count), '0);
      n0 = n_starts;
      do_start;
      chk("nom_word0", SS'(core_state[31:0]), SS'(32'h0));
      chk("nom_word11", SS'(core_state[383:352]), SS'(32'hB));
      run_core(3, 1'b0);
      chk("nom_one_pulse", SS'(n_starts - n0), SS'(1));
      unload(3);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("bp_dout_word", SS'(dout_word), SS'(32'hFFFF_FFFC));
         chk("bp_word_count", SS'(word_count), SS'(3));
         chk("bp_dout_valid", SS'(dout_valid), SS'(1));
      end
      unload(9);
      chk("nom_idle_din_ready", SS'(din_ready), SS'(1));
      chk("nom_idle_dout_valid", SS'(dout_valid), '0);
      chk("nom_idle_state", SS'(dbg_state), '0);
      chk("nom_restored", core_state, m_buf);
      chk("nom_fault", SS'(fault), '0);

      // Fault run with ignored inputs during RUN
      for (int i = 0; i < NW; i++) load_word($urandom);
      do_start;
      start = 1'b1; din_valid = 1'b1; din_word = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         tick;
         chk("ign_busy", SS'(busy), SS'(1));
         chk("ign_din_ready", SS'(din_ready), '0);
         chk("ign_core_start", SS'(core_start), '0);
         chk("ign_core_state", core_state, m_buf);
      end
      start = 1'b0;
      tick;
      start = 1'b1;
      run_core(2, 1'b1);
      chk("flt_no_restart", SS'(core_start), '0);
      chk("flt_din_held_off", SS'(din_ready), '0);
      start = 1'b0; din_valid = 1'b0;
      unload(5);
      chk("flt_mid_unload", SS'(fault), SS'(1));
      unload(7);
      chk("flt_idle", SS'(fault), SS'(1));

      // Over-load of 13 words, then clear fault with the next start
      for (int i = 0; i < 13; i++) load_word(32'h100 + 32'(i));
      chk("ovl_wc", SS'(word_count), SS'(1));
      chk("ovl_fault_kept", SS'(fault), SS'(1));
      do_start;
      chk("ovl_fault_clr", SS'(fault), '0);
      chk("ovl_word0", SS'(core_state[31:0]), SS'(32'h101));
      chk("ovl_word11", SS'(core_state[383:352]), SS'(32'h10C));
      run_core(4, 1'b0);
      unload(12);

      // Reset during RUN, then a late core_done
      for (int i = 0; i < NW; i++) load_word($urandom);
      do_start;
      tick;
      tick;
      aresetn = 1'b0;
      #1;
      chk_reset("rst_run");
      m_buf = '0; m_count = 0; exp_q.delete();
      tick;
      aresetn = 1'b1;
      core_done = 1'b1; core_fault = 1'b1; core_new_state = {NW{32'hA5A5_A5A5}};
      tick;
      core_done = 1'b0; core_fault = 1'b0; core_new_state = '0;
      chk_reset("late_done");

      // Reset after 6 unloaded words, then a fresh run
      for (int i = 0; i < NW; i++) load_word($urandom);
      do_start;
      run_core(3, 1'b0);
      unload(6);
      aresetn = 1'b0;
      #1;
      chk_reset("rst_unload");
      m_buf = '0; m_count = 0; exp_q.delete();
      tick;
      aresetn = 1'b1;
      tick;
      chk_reset("rst_unload_rel");
      for (int i = 0; i < NW; i++) load_word(32'hC0DE_0000 + 32'(i));
      do_start;
      run_core(5, 1'b1);
      unload(12);
      chk("fresh_fault", SS'(fault), SS'(1));
      chk("fresh_restored", core_state, m_buf);
      chk("fresh_q_drained", SS'(exp_q.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/friet_state_io_buffer.md
# friet_state_io_buffer

Word-serial state buffer between the AXI4-lite register front end and the Friet permutation core. Assembles 32-bit register writes into the 384-bit permutation state and launches the core. Captures the new state and the fault flag from the core, then presents the result back as 32-bit words for register reads. Every transfer uses a valid/ready handshake. The block owns the state register, so the core sees a stable input for the whole run.

## Interface
- STATE_SIZE, 384, permutation state width; must be a multiple of WORD_SIZE
- WORD_SIZE, 32, register word width; WORDS = STATE_SIZE/WORD_SIZE = 12

- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- din_word  in  WORD_SIZE  state word to load
- din_valid  in  1  din_word valid
- din_ready  out  1  buffer accepts a word
- start  in  1  request permutation of the buffered state
- dout_word  out  WORD_SIZE  result word
- dout_valid  out  1  dout_word valid
- dout_ready  in  1  consumer takes dout_word
- core_start  out  1  one-cycle start pulse to the core
- core_state  out  STATE_SIZE  buffer contents, driven directly from the register
- core_new_state  in  STATE_SIZE  core result, valid while core_done=1
- core_done  in  1  core result valid
- core_fault  in  1  core fault indication, sampled with core_done
- busy  out  1  core run in progress
- fault  out  1  sticky fault of the last run
- word_count  out  4  words transferred in the current load/unload, 0..WORDS-1

## Operation
- States:
  - IDLE: din_ready=1, dout_valid=0.
  - RUN: din_ready=0, dout_valid=0, busy=1.
  - DONE: din_ready=0, dout_valid=1.
- Load (IDLE, din_valid&din_ready): buf <= {din_word, buf[STATE_SIZE-1:WORD_SIZE]}; word_count wraps WORDS-1 -> 0.
  - The first word of a 12-word burst ends in bits [31:0].
  - More than 12 words: the oldest words are shifted out; no error is raised.
- IDLE & start: core_start=1 for exactly one cycle, word_count<=0, fault<=0, go to RUN.
  - A partial load is accepted; the buffer is used as it stands.
- RUN: buf is frozen. On core_done=1: buf<=core_new_state, fault<=core_fault, go to DONE.
- DONE: dout_word=buf[WORD_SIZE-1:0].
  - On each handshake: buf <= {buf[WORD_SIZE-1:0], buf[STATE_SIZE-1:WORD_SIZE]} (rotate, so the buffer is restored after 12 reads). word_count increments.
  - On the handshake with word_count=WORDS-1: word_count<=0, go to IDLE.
- start in RUN or DONE: ignored.
- din_valid in RUN or DONE: not accepted (din_ready=0); the word is held off, not dropped.
- core_done in IDLE or DONE: ignored.
- core_done coincident with start in RUN: core_done is captured; start is ignored.
- fault holds its value through DONE and IDLE until the next accepted start.

## Timing
- Reset (async assert, sync release effect):
  - state=IDLE, buf=0, word_count=0.
  - core_start=0, busy=0, fault=0, dout_valid=0, din_ready=1.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- Load throughput: 1 word/cycle.
- start sampled at edge k: core_start=1 and busy=1 during cycle k+1; core_start=0 from k+2.
- core_done sampled at edge m: dout_valid=1 and result word 0 available in cycle m+1; busy=0 from m+1.
- Unload throughput: 1 word/cycle. With dout_ready=0, dout_word and dout_valid stay stable indefinitely.
- Minimum overhead around a core run of L cycles:
  - start to first result word: L+2 cycles.
  - Full round trip for 12 words each way: 12 + L + 2 + 12 cycles.
- Reset asserted in any state (mid-load, RUN, mid-unload) returns immediately to reset values.
  - A core_done arriving after reset release is ignored (state is IDLE).

## Test plan
- Reset: hold aresetn=0 with random inputs -> din_ready=1, all other outputs 0; after release, word_count=0, core_state=0.
- Nominal run:
  - Stimulus: load words 0x00000000..0x0000000B, pulse start; core model returns ~core_state after 3 cycles with core_fault=0.
  - Response: core_state=0x0000000B_..._00000000 during RUN; one core_start pulse; dout words 0xFFFFFFFF, 0xFFFFFFFE, ..., 0xFFFFFFF4 in order; fault=0; state returns to IDLE after the 12th read.
- Backpressure: in DONE, dout_ready=0 for 5 cycles after word 3 -> dout_word=0xFFFFFFFC stable, word_count=3; sequence resumes correctly.
- Fault and ignored inputs:
  - Core returns core_fault=1 -> fault=1 through unload and IDLE.
  - start, din_valid and a second start during RUN -> no effect, busy=1, din_ready=0.
  - Next accepted start -> fault=0.
- Over-load: load 13 words 0x100..0x10C then start -> core_state word 0 = 0x101, word 11 = 0x10C; word_count=1 before start.
- Reset mid-operation: assert aresetn=0 during RUN, and separately after 6 unloaded words -> reset values immediately; late core_done ignored; a fresh 12-word load and run completes correctly.
